registro_barcos: RTL and testbench

REGISTRO_BARCOS -- requirements
Module: registro_barcos

---
 rtl/barcos_pkg.sv | 17 +
 rtl/barco_hp.sv | 30 +++
 rtl/registro_barcos.sv | 119 +++++++++++
 tb/tb_registro_barcos.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/barcos_pkg.sv
// Shared types and constants for the ship register: default fleet size,
// ship-id and hit-point widths, and the game FSM states.
package barcos_pkg;

   localparam int unsigned NUM_BARCOS_DEF = 5;
   localparam int unsigned ID_W           = 3;
   localparam int unsigned HP_W           = 3;

   typedef logic [ID_W-1:0] ship_id_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAYING,
      ST_OVER
   } state_t;

endpackage

// File: rtl/barco_hp.sv
// Hit-point register for one ship: reload on start, saturating decrement,
// alive flag and a combinational "this decrement sinks it" event.
module barco_hp
   import barcos_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic [HP_W-1:0] i_load_val,
   input  logic            i_dec,
   output logic            o_alive,
   output logic            o_sunk
);

   logic [HP_W-1:0] r_hp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hp <= '0;
      end else if (i_load) begin
         r_hp <= i_load_val;
      end else if (i_dec && (r_hp != '0)) begin
         r_hp <= r_hp - 1'b1;
      end
   end

   assign o_alive = (r_hp != '0);
   assign o_sunk  = i_dec && !i_load && (r_hp == HP_W'(1));

endmodule

// File: rtl/registro_barcos.sv
// Ship register for the battleship game: tracks per-ship hit points, reports
// sinkings and game over. Optional hits_total counter under BARCOS_HITCOUNT_EN.
module registro_barcos
   import barcos_pkg::*;
#(
   parameter int unsigned NUM_BARCOS = NUM_BARCOS_DEF
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  hit_valid,
   input  logic [2:0]            hit_id,
   output logic                  hit_ready,
   output logic [NUM_BARCOS-1:0] barcos,
   output logic                  sunk_valid,
   output logic [2:0]            sunk_id,
   output logic                  game_over
`ifdef BARCOS_HITCOUNT_EN
  ,output logic [4:0]            hits_total
`endif
);

   state_t                r_state;
   state_t                w_next;
   logic                  w_accept;
   logic [NUM_BARCOS-1:0] w_dec;
   logic [NUM_BARCOS-1:0] w_alive;
   logic [NUM_BARCOS-1:0] w_sunk;
   ship_id_t              w_sunk_id;
   logic                  r_sunk_valid;
   ship_id_t              r_sunk_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Game ends when the ship sinking this cycle was the last one alive.
   always_comb begin
      w_next    = r_state;
      hit_ready = 1'b0;
      game_over = 1'b0;
      if (r_state == ST_PLAYING && !start) begin
         hit_ready = 1'b1;
      end
      if (r_state == ST_OVER) begin
         game_over = 1'b1;
      end
      if (start) begin
         w_next = ST_PLAYING;
      end else if ((r_state == ST_PLAYING) && (|w_sunk) && ((w_alive & ~w_sunk) == '0)) begin
         w_next = ST_OVER;
      end
   end

   assign w_accept = hit_valid && hit_ready;

   for (genvar g = 0; g < NUM_BARCOS; g++) begin : g_ship
      assign w_dec[g] = w_accept && (hit_id == ship_id_t'(g));

      barco_hp u_hp (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_load     (start),
         .i_load_val (HP_W'(g + 1)),
         .i_dec      (w_dec[g]),
         .o_alive    (w_alive[g]),
         .o_sunk     (w_sunk[g])
      );
   end

   always_comb begin
      w_sunk_id = '0;
      for (int unsigned i = 0; i < NUM_BARCOS; i++) begin
         if (w_sunk[i]) begin
            w_sunk_id = ship_id_t'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sunk_valid <= 1'b0;
         r_sunk_id    <= '0;
      end else if (start) begin
         r_sunk_valid <= 1'b0;
      end else begin
         r_sunk_valid <= |w_sunk;
         if (|w_sunk) begin
            r_sunk_id <= w_sunk_id;
         end
      end
   end

   assign barcos     = w_alive;
   assign sunk_valid = r_sunk_valid;
   assign sunk_id    = r_sunk_id;

`ifdef BARCOS_HITCOUNT_EN
   logic [4:0] r_hits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hits <= '0;
      end else if (start) begin
         r_hits <= '0;
      end else if ((|(w_dec & w_alive)) && (r_hits != '1)) begin
         r_hits <= r_hits + 1'b1;
      end
   end

   assign hits_total = r_hits;
`endif

endmodule

// File: tb/tb_registro_barcos.sv
// Self-checking bench for registro_barcos: directed scenarios plus random
// play against an array-based game model.
module tb_registro_barcos;

   localparam int NB = 5;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          hit_valid;
   logic [2:0]    hit_id;
   logic          hit_ready;
   logic [NB-1:0] barcos;
   logic          sunk_valid;
   logic [2:0]    sunk_id;
   logic          game_over;
`ifdef BARCOS_HITCOUNT_EN
   logic [4:0]    hits_total;
`endif

   registro_barcos #(.NUM_BARCOS(NB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .hit_valid  (hit_valid),
      .hit_id     (hit_id),
      .hit_ready  (hit_ready),
      .barcos     (barcos),
      .sunk_valid (sunk_valid),
      .sunk_id    (sunk_id),
      .game_over  (game_over)
`ifdef BARCOS_HITCOUNT_EN
     ,.hits_total (hits_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Game model: 0 = idle, 1 = playing, 2 = over
   int m_phase;
   int m_hp [NB];
   int m_sunk;
   int m_sid;
   int m_hits;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      for (int i = 0; i < NB; i++) m_hp[i] = 0;
      m_sunk = 0;
      m_sid  = 0;
      m_hits = 0;
   endtask

   task automatic model_edge(input bit s, input bit hv, input int id);
      int alive_left;
      if (s) begin
         m_phase = 1;
         for (int i = 0; i < NB; i++) m_hp[i] = i + 1;
         m_sunk = 0;
         m_hits = 0;
      end else begin
         m_sunk = 0;
         if (hv && m_phase == 1 && id < NB && m_hp[id] > 0) begin
            m_hp[id] = m_hp[id] - 1;
            if (m_hits < 31) m_hits++;
            if (m_hp[id] == 0) begin
               m_sunk = 1;
               m_sid  = id;
               alive_left = 0;
               for (int i = 0; i < NB; i++) if (m_hp[i] > 0) alive_left++;
               if (alive_left == 0) m_phase = 2;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      int mask;
      mask = 0;
      for (int i = 0; i < NB; i++) if (m_hp[i] > 0) mask += (1 << i);
      check({tag, ":barcos"},    int'(barcos),     mask);
      check({tag, ":sunk_valid"}, int'(sunk_valid), m_sunk);
      check({tag, ":sunk_id"},   int'(sunk_id),    m_sid);
      check({tag, ":game_over"}, int'(game_over),  (m_phase == 2) ? 1 : 0);
      check({tag, ":hit_ready"}, int'(hit_ready),  (m_phase == 1 && !start) ? 1 : 0);
`ifdef BARCOS_HITCOUNT_EN
      check({tag, ":hits_total"}, int'(hits_total), m_hits);
`endif
   endtask

   task automatic step(input bit s, input bit hv, input int id, input string tag);
      @(negedge clk);
      start     = s;
      hit_valid = hv;
      hit_id    = 3'(id);
      #1;
      check({tag, ":ready_pre"}, int'(hit_ready), (m_phase == 1 && !s) ? 1 : 0);
      @(posedge clk);
      model_edge(s, hv, id);
      #1;
      check_all(tag);
   endtask

   task automatic pulse_reset(input string tag);
      start     = 1'b0;
      hit_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      start     = 1'b0;
      hit_valid = 1'b0;
      hit_id    = 3'd0;
      rst_n     = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b0, 1'b1, 0, "idle_hit");
      step(1'b1, 1'b0, 0, "start");
      step(1'b0, 1'b1, 0, "hit0");
      step(1'b0, 1'b0, 0, "after_sink0");
      for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 4, "hit4");
      step(1'b0, 1'b1, 7, "bad_id7");
      step(1'b0, 1'b1, 5, "bad_id5");
      step(1'b1, 1'b1, 2, "start_with_hit");
      step(1'b0, 1'b1, 3, "hit3");
      pulse_reset("mid_reset");
      step(1'b0, 1'b1, 1, "post_reset_hit");
      step(1'b1, 1'b0, 0, "restart");
      for (int s = 0; s < NB; s++)
         for (int k = 0; k <= s; k++) step(1'b0, 1'b1, s, "b2b");
      step(1'b0, 1'b1, 2, "over_hit");
      step(1'b0, 1'b0, 0, "over_idle");

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset("rnd_reset");
         end else begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), "rnd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
